// File: rtl/alias_bus_pkg.sv
// Shared definitions for the alias bus arbiter: default sizing, lock FSM states,
// and a one-hot to index helper used by the arbiter top.
package alias_bus_pkg;

    localparam int DEF_WIDTH    = 16;
    localparam int DEF_NCH      = 3;
    localparam int DEF_CW       = 8;
    localparam int DEF_LOCK_MAX = 4;
    localparam logic [15:0] DEF_RESET_VAL = 16'habcd;

    // Widest grant vector the index helper understands; NCH must not exceed it.
    localparam int MAX_CH = 32;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    // Converts a one-hot (or all-zero) vector to the index of its set bit.
    // An all-zero input yields 0; callers gate on "any grant" separately.
    function automatic int unsigned onehot_to_idx(input logic [MAX_CH-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (oh[i]) begin
                idx = idx | unsigned'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/alias_bus_arbiter_if.sv
// Bundle of the per-channel write requests and the shared read view.
// master = producer side driving requests, slave = the arbiter itself.
interface alias_bus_arbiter_if
    import alias_bus_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NCH   = DEF_NCH,
    parameter int CW    = DEF_CW
) ();

    localparam int OW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0]       req;
    logic [NCH-1:0]       lock;
    logic [NCH*WIDTH-1:0] wdata;
    logic [NCH-1:0]       gnt;
    logic [NCH*WIDTH-1:0] view;
    logic                 written;
    logic [OW-1:0]        owner;
    logic [CW-1:0]        conflict_cnt;

    modport master (
        output req, lock, wdata,
        input  gnt, view, written, owner, conflict_cnt
    );

    modport slave (
        input  req, lock, wdata,
        output gnt, view, written, owner, conflict_cnt
    );

endinterface

// File: rtl/alias_bus_arbiter_rr_arbiter.sv
// Round-robin arbiter with an override: when force_valid is set and the forced
// channel is requesting, it wins outright; otherwise the search starts at
// rr_ptr and wraps modulo NCH. Output is one-hot or zero.
module rr_arbiter #(
    parameter int NCH = 3,
    parameter int PW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] req,
    input  logic [PW-1:0]  rr_ptr,
    input  logic [PW-1:0]  force_idx,
    input  logic           force_valid,
    output logic [NCH-1:0] gnt
);

    logic [PW-1:0] idx;
    logic          found;

    // Pick the single winner: forced owner first, else first requester from rr_ptr.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        if (force_valid && req[force_idx]) begin
            gnt[force_idx] = 1'b1;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                idx = PW'((int'(rr_ptr) + k) % NCH);
                if (!found && req[idx]) begin
                    gnt[idx] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alias_bus_arbiter.sv
// Multi-writer shared word. NCH channels compete to write one WIDTH-bit value;
// a round-robin arbiter picks one winner per cycle, a lock FSM lets the winner
// keep ownership for up to LOCK_MAX consecutive grants, and a saturating
// counter tallies cycles where requesters present differing data.
module alias_bus_arbiter
    import alias_bus_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               NCH       = DEF_NCH,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEF_RESET_VAL),
    parameter int               CW        = DEF_CW,
    parameter int               LOCK_MAX  = DEF_LOCK_MAX
) (
    input  logic              clk,
    input  logic              rst_n,
    alias_bus_arbiter_if.slave bus
);

    localparam int OW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int LRW = $clog2(LOCK_MAX + 1);

    logic [WIDTH-1:0] word;
    logic [OW-1:0]    owner_q;
    logic [OW-1:0]    rr_ptr;
    logic             written_q;
    logic [CW-1:0]    conflict_q;

    lock_state_e      state_q;
    lock_state_e      state_d;
    logic [LRW-1:0]   run_q;
    logic [LRW-1:0]   run_d;

    logic [WIDTH-1:0] wdata_arr [NCH];
    logic [NCH-1:0]   gnt;
    logic [OW-1:0]    g_idx;
    logic             commit;
    logic             locked;

    logic [WIDTH-1:0] ref_data;
    logic             have_ref;
    logic             conflict;

    for (genvar i = 0; i < NCH; i++) begin : g_unpack
        assign wdata_arr[i] = bus.wdata[i*WIDTH +: WIDTH];
    end

    assign locked = (state_q == LOCKED);

    rr_arbiter #(
        .NCH (NCH),
        .PW  (OW)
    ) u_rr (
        .req         (bus.req),
        .rr_ptr      (rr_ptr),
        .force_idx   (owner_q),
        .force_valid (locked),
        .gnt         (gnt)
    );

    assign commit = |gnt;
    assign g_idx  = OW'(onehot_to_idx(MAX_CH'(gnt)));

    assign bus.gnt          = gnt;
    assign bus.view         = {NCH{word}};
    assign bus.written      = written_q;
    assign bus.owner        = owner_q;
    assign bus.conflict_cnt = conflict_q;

    // A conflict is any cycle where two requesters offer different data;
    // identical data from several writers is harmless and not counted.
    always_comb begin
        ref_data = '0;
        have_ref = 1'b0;
        conflict = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (bus.req[i]) begin
                if (!have_ref) begin
                    ref_data = wdata_arr[i];
                    have_ref = 1'b1;
                end else if (wdata_arr[i] != ref_data) begin
                    conflict = 1'b1;
                end
            end
        end
    end

    // Storage, ownership, round-robin pointer and conflict counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word       <= RESET_VAL;
            owner_q    <= '0;
            written_q  <= 1'b0;
            rr_ptr     <= '0;
            conflict_q <= '0;
        end else begin
            if (commit) begin
                word      <= wdata_arr[g_idx];
                owner_q   <= g_idx;
                written_q <= 1'b1;
                rr_ptr    <= (g_idx == OW'(NCH - 1)) ? '0 : g_idx + OW'(1);
            end
            if (conflict && (conflict_q != '1)) begin
                conflict_q <= conflict_q + CW'(1);
            end
        end
    end

    // Lock FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= UNLOCKED;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    // Lock FSM next state: enter on a locked commit, count consecutive owner
    // grants, and force release after LOCK_MAX so rr_ptr hands priority onward.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        unique case (state_q)
            UNLOCKED: begin
                run_d = '0;
                if (commit && bus.lock[g_idx] && (LOCK_MAX > 1)) begin
                    state_d = LOCKED;
                    run_d   = LRW'(1);
                end
            end
            LOCKED: begin
                if (bus.req[owner_q] && bus.lock[owner_q]) begin
                    if ((run_q + LRW'(1)) == LRW'(LOCK_MAX)) begin
                        state_d = UNLOCKED;
                        run_d   = '0;
                    end else begin
                        run_d = run_q + LRW'(1);
                    end
                end else begin
                    state_d = UNLOCKED;
                    run_d   = '0;
                end
            end
            default: begin
                state_d = UNLOCKED;
                run_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_alias_bus_arbiter.sv
// Directed bench for alias_bus_arbiter. A second instance with a 2-bit conflict
// counter shares all inputs so counter saturation is observed on the same traffic.
module tb_alias_bus_arbiter;

    logic clk;
    logic rst_n;

    int tests_run;
    int tests_failed;

    alias_bus_arbiter_if #(.WIDTH(16), .NCH(3), .CW(8)) bus  ();
    alias_bus_arbiter_if #(.WIDTH(16), .NCH(3), .CW(2)) bus2 ();

    alias_bus_arbiter #(
        .WIDTH(16), .NCH(3), .RESET_VAL(16'habcd), .CW(8), .LOCK_MAX(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    alias_bus_arbiter #(
        .WIDTH(16), .NCH(3), .RESET_VAL(16'habcd), .CW(2), .LOCK_MAX(4)
    ) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    assign bus2.req   = bus.req;
    assign bus2.lock  = bus.lock;
    assign bus2.wdata = bus.wdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle's inputs at the falling edge and let combinational logic settle.
    task automatic applyStimulus(input logic rn, input logic [2:0] r, input logic [2:0] l,
                                 input logic [15:0] d0, input logic [15:0] d1,
                                 input logic [15:0] d2);
        @(negedge clk);
        rst_n     = rn;
        bus.req   = r;
        bus.lock  = l;
        bus.wdata = {d2, d1, d0};
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkViews(input string tag, input logic [15:0] exp);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("%s view[%0d]", tag, i), 32'(bus.view[i*16 +: 16]), 32'(exp));
        end
    endtask

    logic [2:0]  exp_rr   [4] = '{3'b100, 3'b001, 3'b010, 3'b100};
    logic [15:0] data_rr  [3] = '{16'ha0a0, 16'hb1b1, 16'hc2c2};
    logic [2:0]  exp_lock [6] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b001};

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        bus.req      = '0;
        bus.lock     = '0;
        bus.wdata    = '0;

        // Reset state
        applyStimulus(1'b0, 3'b000, 3'b000, 16'h0, 16'h0, 16'h0);
        applyStimulus(1'b0, 3'b000, 3'b000, 16'h0, 16'h0, 16'h0);
        applyStimulus(1'b1, 3'b000, 3'b000, 16'h0, 16'h0, 16'h0);
        checkViews("reset", 16'habcd);
        checkOutput("reset written", 32'(bus.written), 32'd0);
        checkOutput("reset cnt", 32'(bus.conflict_cnt), 32'd0);
        checkOutput("reset gnt", 32'(bus.gnt), 32'd0);
        checkOutput("reset owner", 32'(bus.owner), 32'd0);

        // Single write from channel 1
        applyStimulus(1'b1, 3'b010, 3'b000, 16'h0, 16'h1234, 16'h0);
        checkOutput("single gnt", 32'(bus.gnt), 32'b010);
        checkViews("single pre", 16'habcd);
        applyStimulus(1'b1, 3'b000, 3'b000, 16'h0, 16'h0, 16'h0);
        checkViews("single post", 16'h1234);
        checkOutput("single owner", 32'(bus.owner), 32'd1);
        checkOutput("single written", 32'(bus.written), 32'd1);
        checkOutput("idle gnt", 32'(bus.gnt), 32'd0);

        // Round-robin with all three requesting distinct data (rr_ptr starts at 2)
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 3'b111, 3'b000, data_rr[0], data_rr[1], data_rr[2]);
            checkOutput($sformatf("rr gnt %0d", k), 32'(bus.gnt), 32'(exp_rr[k]));
            checkOutput($sformatf("rr cnt %0d", k), 32'(bus.conflict_cnt), 32'(k));
            checkOutput($sformatf("rr cnt2 %0d", k), 32'(bus2.conflict_cnt), 32'(k));
        end
        applyStimulus(1'b1, 3'b000, 3'b000, 16'h0, 16'h0, 16'h0);
        checkViews("rr final", 16'hc2c2);
        checkOutput("rr final cnt", 32'(bus.conflict_cnt), 32'd4);
        checkOutput("sat cnt2", 32'(bus2.conflict_cnt), 32'd3);
        checkOutput("rr final owner", 32'(bus.owner), 32'd2);

        // Lock on channel 0: four grants, forced release to ch1, then ch0 again
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, 3'b011, 3'b001, 16'h1111, 16'h2222, 16'h0);
            checkOutput($sformatf("lock gnt %0d", k), 32'(bus.gnt), 32'(exp_lock[k]));
        end

        // Equal data on ch0/ch2 (ch0 still holds the lock) is not a conflict
        applyStimulus(1'b1, 3'b101, 3'b000, 16'h5555, 16'h9999, 16'h5555);
        checkOutput("lock end cnt", 32'(bus.conflict_cnt), 32'd10);
        checkOutput("lock end cnt2", 32'(bus2.conflict_cnt), 32'd3);
        checkOutput("equal gnt", 32'(bus.gnt), 32'b001);

        // Lock onto channel 1 (rr_ptr=1 after the unlocking ch0 commit)
        applyStimulus(1'b1, 3'b011, 3'b011, 16'h7777, 16'h8888, 16'h0);
        checkViews("equal", 16'h5555);
        checkOutput("equal cnt", 32'(bus.conflict_cnt), 32'd10);
        checkOutput("relock gnt", 32'(bus.gnt), 32'b010);

        // Reset while locked: forced grant to ch1 even though rr_ptr points at 2
        applyStimulus(1'b0, 3'b011, 3'b011, 16'h7777, 16'h8888, 16'h0);
        checkOutput("locked forced gnt", 32'(bus.gnt), 32'b010);
        checkViews("pre reset", 16'h8888);
        checkOutput("pre reset cnt", 32'(bus.conflict_cnt), 32'd11);

        applyStimulus(1'b1, 3'b110, 3'b000, 16'h0, 16'haaaa, 16'hbbbb);
        checkViews("post reset", 16'habcd);
        checkOutput("post reset written", 32'(bus.written), 32'd0);
        checkOutput("post reset owner", 32'(bus.owner), 32'd0);
        checkOutput("post reset cnt", 32'(bus.conflict_cnt), 32'd0);
        checkOutput("post reset cnt2", 32'(bus2.conflict_cnt), 32'd0);
        checkOutput("post reset gnt", 32'(bus.gnt), 32'b010);

        applyStimulus(1'b1, 3'b000, 3'b000, 16'h0, 16'h0, 16'h0);
        checkViews("after reset write", 16'haaaa);
        checkOutput("after reset owner", 32'(bus.owner), 32'd1);
        checkOutput("after reset cnt", 32'(bus.conflict_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
